// File: rtl/bcd_to_bin.sv
// Sequential three-digit BCD to 10-bit binary converter (reverse double-dabble, one bit per clock).
// Optional input digit range check is enabled by defining BCD2BIN_RANGE_CHECK_EN.
module bcd_to_bin (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    output logic       busy,
    output logic       done,
    output logic [9:0] bin,
    output logic       ovf,
    output logic       err
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Control state kept in one struct so checkers can bind to a single signal.
    typedef struct packed {
        state_t     state;
        logic [3:0] iter;
    } ctrl_t;

    ctrl_t       ctrl;
    logic [11:0] bcd;
    logic [9:0]  sh;
    logic [11:0] bcd_nxt;
    logic [9:0]  sh_nxt;
    logic        range_ok;

`ifdef BCD2BIN_RANGE_CHECK_EN
    assign range_ok = (d1 <= 4'd9) && (d2 <= 4'd9) && (d3 <= 4'd9);
`else
    assign range_ok = 1'b1;
    assign err      = 1'b0;
`endif

    // One reverse double-dabble step: shift {bcd, sh} right, then pull every
    // digit that landed at 8 or above back down by 3 (no inter-digit carry).
    always_comb begin
        bcd_nxt = {1'b0, bcd[11:1]};
        sh_nxt  = {bcd[0], sh[9:1]};
        for (int i = 0; i < 3; i++) begin
            if (bcd_nxt[4*i+3]) begin
                bcd_nxt[4*i +: 4] = bcd_nxt[4*i +: 4] - 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl.state <= IDLE;
            ctrl.iter  <= 4'd0;
            bcd        <= 12'd0;
            sh         <= 10'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            bin        <= 10'd0;
            ovf        <= 1'b0;
`ifdef BCD2BIN_RANGE_CHECK_EN
            err        <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (ctrl.state)
                IDLE: begin
                    if (start) begin
                        if (range_ok) begin
                            bcd        <= {d3, d2, d1};
                            sh         <= 10'd0;
                            ctrl.iter  <= 4'd0;
                            ctrl.state <= SHIFT;
                            busy       <= 1'b1;
                        end else begin
                            // Rejected request answers immediately without entering SHIFT.
                            done <= 1'b1;
                            bin  <= 10'd0;
                            ovf  <= 1'b0;
`ifdef BCD2BIN_RANGE_CHECK_EN
                            err  <= 1'b1;
`endif
                        end
                    end
                end
                SHIFT: begin
                    bcd <= bcd_nxt;
                    sh  <= sh_nxt;
                    if (ctrl.iter == 4'd9) begin
                        bin        <= sh_nxt;
                        ovf        <= |sh_nxt[9:8];
`ifdef BCD2BIN_RANGE_CHECK_EN
                        err        <= 1'b0;
`endif
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        ctrl.iter  <= 4'd0;
                        ctrl.state <= IDLE;
                    end else begin
                        ctrl.iter <= ctrl.iter + 4'd1;
                    end
                end
                default: begin
                    ctrl.state <= IDLE;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: stimulus pushes expected {err, ovf, bin} into a queue,
// a negedge monitor pops and compares on every done pulse.
module tb_bcd_to_bin;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] d1, d2, d3;
    logic       busy, done, ovf, err;
    logic [9:0] bin;

    logic [11:0] exp_q[$];
    int n_vec  = 0;
    int n_bad  = 0;
    int n_done = 0;

    bcd_to_bin dut (
        .clk(clk), .rst(rst), .start(start),
        .d1(d1), .d2(d2), .d3(d3),
        .busy(busy), .done(done), .bin(bin), .ovf(ovf), .err(err)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    function automatic logic [11:0] pack(input logic e, input logic o, input logic [9:0] b);
        return {e, o, b};
    endfunction

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: got err=%b ovf=%b bin=%h, required no done", err, ovf, bin);
            end else begin
                check("result", {20'd0, err, ovf, bin}, {20'd0, exp_q.pop_front()});
            end
        end
    end

    // driver tasks: called at a negedge, return at the negedge after the start edge
    task automatic start_conv(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u,
                              input bit push, input logic [11:0] req);
        if (push) exp_q.push_back(req);
        d3 = h; d2 = t; d1 = u;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        int busy_bad;
        lat = 0;
        busy_bad = 0;
        while (!done && lat < 30) begin
            if (busy !== 1'b1) busy_bad++;
            @(negedge clk);
            lat++;
        end
        check("busy_while_converting", busy_bad, 0);
        check("done_seen", {31'd0, done}, 1);
        check("busy_at_done", {31'd0, busy}, 0);
    endtask

    initial begin
        int lat;
        int done_snap;
        rst = 1'b1; start = 1'b0; d1 = 4'd0; d2 = 4'd0; d3 = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_bin",  {22'd0, bin}, 0);
        check("reset_ovf",  {31'd0, ovf}, 0);
        check("reset_err",  {31'd0, err}, 0);

        // 255 -> largest value that fits 8 bits
        start_conv(4'd2, 4'd5, 4'd5, 1, pack(1'b0, 1'b0, 10'h0FF));
        wait_done(lat);
        check("latency_255", lat, 10);

        // 999 then 000 started in the done cycle
        start_conv(4'd9, 4'd9, 4'd9, 1, pack(1'b0, 1'b1, 10'h3E7));
        wait_done(lat);
        start_conv(4'd0, 4'd0, 4'd0, 1, pack(1'b0, 1'b0, 10'h000));
        wait_done(lat);
        check("back_to_back_gap", lat + 1, 11);

        // 8-bit boundary on both sides
        start_conv(4'd2, 4'd5, 4'd6, 1, pack(1'b0, 1'b1, 10'h100));
        wait_done(lat);
        start_conv(4'd1, 4'd2, 4'd8, 1, pack(1'b0, 1'b0, 10'h080));
        wait_done(lat);

        // start re-asserted while busy must be ignored
        start_conv(4'd0, 4'd4, 4'd2, 1, pack(1'b0, 1'b0, 10'h02A));
        done_snap = n_done;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                start = 1'b1; d3 = 4'd9; d2 = 4'd9; d1 = 4'd9;
            end
        end
        start = 1'b0;
        wait_done(lat);
        check("latency_ignored_start", lat + 5, 10);
        repeat (15) @(negedge clk);
        check("single_done_ignored_start", n_done - done_snap, 1);

        // reset in the middle of a conversion
        start_conv(4'd1, 4'd2, 4'd3, 0, 12'd0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_busy", {31'd0, busy}, 0);
        check("midreset_bin",  {22'd0, bin}, 0);
        check("midreset_ovf",  {31'd0, ovf}, 0);
        done_snap = n_done;
        repeat (20) @(negedge clk);
        check("midreset_no_done", n_done - done_snap, 0);
        start_conv(4'd1, 4'd2, 4'd3, 1, pack(1'b0, 1'b0, 10'h07B));
        wait_done(lat);
        check("latency_123", lat, 10);

`ifdef BCD2BIN_RANGE_CHECK_EN
        start_conv(4'd0, 4'd0, 4'hA, 1, pack(1'b1, 1'b0, 10'h000));
        check("range_done_next_cycle", {31'd0, done}, 1);
        check("range_busy_low", {31'd0, busy}, 0);
        @(negedge clk);
        check("range_busy_after", {31'd0, busy}, 0);
        start_conv(4'd0, 4'd0, 4'd7, 1, pack(1'b0, 1'b0, 10'h007));
        wait_done(lat);
        check("latency_007", lat, 10);
`endif

        repeat (5) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: got timeout, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin.md
# bcd_to_bin

Sequential BCD-to-binary converter: takes three BCD digits (units, tens, hundreds) and produces the 10-bit binary value using reverse double-dabble, one bit per clock. Inverse of the combinational binary-to-BCD stage. Used where user-entered or displayed decimal values are fed back into the 8-bit counter datapath. Start/done handshake, result held until the next conversion.

## Interface
- No parameters; widths are fixed (3 digits in, 10 bits out).
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a conversion; sampled only in IDLE
- d1  in  4  units digit
- d2  in  4  tens digit
- d3  in  4  hundreds digit
- busy  out  1  high while a conversion is in progress
- done  out  1  one-cycle pulse: bin/ovf/err are valid
- bin  out  10  binary result, 0..999
- ovf  out  1  result does not fit 8 bits (bin > 255)
- err  out  1  last request had a digit > 9; only with BCD2BIN_RANGE_CHECK_EN

## Operation
- States: IDLE, SHIFT. A 4-bit iteration counter runs 0..9 in SHIFT.
- IDLE with start=1: capture {d3,d2,d1} into a 12-bit BCD register, clear 10-bit shift register, counter=0, go to SHIFT.
- IDLE with start=0: hold all outputs.
- Each SHIFT cycle: shift the 22-bit concatenation {bcd, sh} right by 1 (bcd[0] enters sh[9], zero enters bcd[11]); then every 4-bit digit of the shifted bcd that is >= 8 has 3 subtracted (4-bit arithmetic, no carry between digits).
- On iteration 9: load bin from final sh, ovf = |final sh[9:8], err=0, pulse done, return to IDLE.
- bin/ovf/err change only on done; hold their values otherwise.
- start while busy=1 is ignored (no queuing, no restart).
- Residual bcd bits after 10 shifts are zero for valid input; not checked.

## Timing
- Reset (rst=1 at an edge): state IDLE, busy=0, done=0, bin=0, ovf=0, err=0, counter=0. Overrides everything including start.
- Reset mid-conversion: conversion discarded, no done pulse, outputs to reset values.
- start sampled high at edge N (IDLE): busy=1 after edge N. Iterations at edges N+1..N+10. After edge N+10: done=1, busy=0, bin/ovf valid. Latency 10 cycles start-to-done.
- done is high exactly one cycle. start may be high in the done cycle; it is accepted (state is IDLE) -> back-to-back conversions every 11 cycles.
- Inputs d1..d3 only need be stable at the start edge.

## Configuration
- Macro BCD2BIN_RANGE_CHECK_EN.
- Defined: at the start edge, if any of d1, d2, d3 > 9, skip SHIFT; after that same edge: done=1, err=1, bin=0, ovf=0, busy stays 0 (latency 1 cycle). Valid inputs convert normally with err=0.
- Undefined: no check; invalid digits go through the normal 10-cycle algorithm (result unspecified but deterministic), err tied to 0.

## Test plan
- Reset then d3,d2,d1=2,5,5, start one cycle -> busy for 10 cycles, done pulse at edge N+10, bin=0x0FF, ovf=0, err=0.
- d3,d2,d1=9,9,9 -> bin=0x3E7, ovf=1; then 0,0,0 started in the done cycle -> second done 11 cycles after first, bin=0x000, ovf=0.
- 2,5,6 -> bin=0x100, ovf=1; 1,2,8 -> bin=0x080, ovf=0.
- Start 0,4,2; re-assert start with 9,9,9 at cycles 3..5 while busy -> single done, bin=0x02A; no extra done.
- Start 1,2,3; assert rst at cycle 5 -> busy=0, bin=0, no done in following 20 cycles; then 1,2,3 converts to 0x07B.
- With BCD2BIN_RANGE_CHECK_EN: d1=0xA, start -> done and err=1 the next cycle, bin=0, busy never high; next valid request (0,0,7) clears err, bin=0x007.
